// File: rtl/seq_alu_pkg.sv
// Shared widths, opcodes and FSM encoding for the sequential ALU,
// plus the combinational evaluator for the single-cycle opcodes.
package seq_alu_pkg;

   localparam int WORD_SIZE = 16;
   localparam int OP_WIDTH  = 3;
   localparam int CNT_WIDTH = 4;

   typedef logic [OP_WIDTH-1:0] op_t;

   localparam op_t OP_PASS = 3'b000;
   localparam op_t OP_ADD  = 3'b001;
   localparam op_t OP_SUB  = 3'b010;
   localparam op_t OP_MUL  = 3'b011;
   localparam op_t OP_AND  = 3'b100;
   localparam op_t OP_OR   = 3'b101;
   localparam op_t OP_XOR  = 3'b110;
   localparam op_t OP_RSVD = 3'b111;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {carry, result}. MUL and the reserved code evaluate to zero here.
   function automatic logic [WORD_SIZE:0] single_op(
      input op_t                  op,
      input logic [WORD_SIZE-1:0] a,
      input logic [WORD_SIZE-1:0] b
   );
      logic [WORD_SIZE:0] res;
      res = '0;
      case (op)
         OP_PASS: res = {1'b0, b};
         OP_ADD:  res = {1'b0, a} + {1'b0, b};
         OP_SUB:  res = {(a < b), a - b};
         OP_AND:  res = {1'b0, a & b};
         OP_OR:   res = {1'b0, a | b};
         OP_XOR:  res = {1'b0, a ^ b};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Command/result bundle between the accumulator datapath and the ALU.
interface seq_alu_if;
   import seq_alu_pkg::*;

   // start is a request taken on any rising edge where busy is low (no queuing
   // while busy); done is a one-cycle strobe marking alu_out/zero/carry valid.
   logic                 start;
   op_t                  op;
   logic [WORD_SIZE-1:0] a;
   logic [WORD_SIZE-1:0] b;
   logic                 busy;
   logic                 done;
   logic [WORD_SIZE-1:0] alu_out;
   logic                 zero;
   logic                 carry;
   state_t               dbg_state;

   modport master (
      output start, op, a, b,
      input  busy, done, alu_out, zero, carry, dbg_state
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, alu_out, zero, carry, dbg_state
   );

endinterface

// File: rtl/seq_alu_shift_add_multiplier.sv
// 16x16 unsigned shift-add multiplier, one partial product per cycle,
// always exactly 16 iterations.
module shift_add_multiplier
   import seq_alu_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WORD_SIZE-1:0]   a,
   input  logic [WORD_SIZE-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [2*WORD_SIZE-1:0] product
);

   logic [2*WORD_SIZE-1:0] mcand_q, mcand_d;
   logic [WORD_SIZE-1:0]   mplier_q, mplier_d;
   logic [2*WORD_SIZE-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic [2*WORD_SIZE-1:0] acc_step;

   // acc_step is the accumulator after this cycle's iteration, so on the last
   // iteration it is already the full product.
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start && !busy_q) begin
         mcand_d  = {{WORD_SIZE{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == CNT_LAST);
   assign product = acc_step;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU feeding the accumulator: single-cycle logic/arith ops and a
// 17-cycle shift-add MUL, with a one-cycle done strobe driving alu_to_ac.
module seq_alu
   import seq_alu_pkg::*;
(
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);

   state_t                 state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   zero_q, zero_d;
   logic                   carry_q, carry_d;
   logic [WORD_SIZE-1:0]   alu_out_q, alu_out_d;

   logic                   accept;
   logic                   mul_start;
   logic                   mul_busy;
   logic                   mul_last;
   logic [2*WORD_SIZE-1:0] mul_product;
   logic [WORD_SIZE:0]     single_res;

   assign accept     = bus.start && !busy_q && !mul_busy;
   assign mul_start  = accept && (bus.op == OP_MUL);
   assign single_res = single_op(bus.op, bus.a, bus.b);

   shift_add_multiplier u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .busy    (mul_busy),
      .done    (mul_last),
      .product (mul_product)
   );

   always_comb begin
      state_d   = state_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      alu_out_d = alu_out_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      case (state_q)
         ST_MULT: begin
            busy_d = 1'b1;
            if (mul_last) begin
               alu_out_d = mul_product[WORD_SIZE-1:0];
               carry_d   = |mul_product[2*WORD_SIZE-1:WORD_SIZE];
               zero_d    = (mul_product[WORD_SIZE-1:0] == '0);
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept, giving 1-cycle throughput back to back.
            state_d = ST_IDLE;
            if (accept) begin
               if (bus.op == OP_MUL) begin
                  busy_d  = 1'b1;
                  state_d = ST_MULT;
               end else begin
                  alu_out_d = single_res[WORD_SIZE-1:0];
                  carry_d   = single_res[WORD_SIZE];
                  zero_d    = (single_res[WORD_SIZE-1:0] == '0);
                  done_d    = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         alu_out_q <= '0;
         zero_q    <= 1'b1;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         alu_out_q <= alu_out_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.alu_out   = alu_out_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.dbg_state = state_q;

endmodule
